serial_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that accepts bytes from the message-printer-side `tx_data`/`new_tx_data`/`tx_busy` handshake and drives the serial line into the AVR Rx pin. It sits between byte producers and the `avr_rx` pad. A small FIFO absorbs bursts, and the AVR's `avr_rx_busy` flow-control signal pauses transmission at frame boundaries.

---
 rtl/serial_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_serial_tx_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: FIFO-buffered 8N1 UART transmitter, paused at frame starts by tx_block.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after D7 (11-bit frames).
module serial_tx_fifo #(
    parameter int CLK_PER_BIT = 100,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   tx_data,
    input  logic                         new_tx_data,
    output logic                         tx_busy,
    input  logic                         tx_block,
    output logic                         tx,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLK_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]      mem_q [FIFO_DEPTH];
    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            busy_q, busy_d, ovf_q, ovf_d, tx_q, tx_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic            push, pop, blk_s, last, can_pop;

    assign blk_s      = sync_q[1];
    assign push       = new_tx_data & ~busy_q;
    assign last       = cnt_q == CW'(CLK_PER_BIT - 1);
    assign can_pop    = (count_q != '0) && !blk_s;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tx_q     <= 1'b1;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            tx_q     <= tx_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    // busy_q gates push, so a write on a full cycle drops even if a pop frees a slot
    always_comb begin
        sync_d   = {sync_q[0], tx_block};
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CNTW'(push) - CNTW'(pop);
        busy_d   = count_d == CNTW'(FIFO_DEPTH);
        ovf_d    = ovf_q | (new_tx_data & busy_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (can_pop) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: if (last) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: if (last) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
`ifdef SERIAL_TX_PARITY_EN
                if (idx_q == 3'd7) state_d = PARITY;
`else
                if (idx_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (last) begin
                cnt_d   = '0;
                state_d = STOP;
            end
`endif
            STOP: if (last) begin
                cnt_d   = '0;
                pop     = can_pop;
                data_d  = can_pop ? mem_q[rd_ptr_q] : data_q;
                state_d = can_pop ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is derived from next-state values so the line changes on the same edge as the state
    always_comb begin
`ifdef SERIAL_TX_PARITY_EN
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? data_d[idx_d] :
               (state_d == PARITY) ? ^data_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 :
               (state_d == DATA)  ? data_d[idx_d] : 1'b1;
`endif
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed bench for serial_tx_fifo with CLK_PER_BIT=4, FIFO_DEPTH=16.
module tb_serial_tx_fifo;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 11 : 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       new_tx_data = 1'b0;
    logic       tx_block = 1'b0;
    logic       tx_busy, tx, overflow;
    logic [4:0] fifo_count;
    int         n_checks = 0;
    int         n_errors = 0;

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .tx_busy(tx_busy), .tx_block(tx_block), .tx(tx), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    // called on the negedge of the first start-bit cycle; ends on the last stop-bit cycle
    task automatic expect_frame(input logic [7:0] b, input int raise_at);
        for (int i = 0; i < FL * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (i == raise_at) tx_block = 1'b1;
            check($sformatf("frame_%02h_c%0d", b, i), 32'(tx), 32'(exp_bit(b, i)));
        end
    endtask

    task automatic queue2(input logic [7:0] a, input logic [7:0] b);
        tx_data = a;
        new_tx_data = 1'b1;
        @(negedge clk);
        check("q2_count_first", 32'(fifo_count), 1);
        check("q2_tx_latency", 32'(tx), 1);
        tx_data = b;
        @(negedge clk);
        new_tx_data = 1'b0;
        check("q2_count_pushpop", 32'(fifo_count), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single byte
        tx_data = 8'hA5;
        new_tx_data = 1'b1;
        @(negedge clk);
        new_tx_data = 1'b0;
        check("single_count", 32'(fifo_count), 1);
        check("single_tx_wait", 32'(tx), 1);
        @(negedge clk);
        expect_frame(8'hA5, -1);
        @(negedge clk);
        check("single_idle_tx", 32'(tx), 1);
        check("single_idle_count", 32'(fifo_count), 0);

        // fill to full while blocked
        tx_block = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i == 15) check("fill_busy_15", 32'(tx_busy), 0);
            if (i == 16) begin
                check("fill_busy_16", 32'(tx_busy), 1);
                check("fill_count_16", 32'(fifo_count), 16);
                check("fill_ovf_before", 32'(overflow), 0);
            end
            tx_data = 8'(8'h10 + i);
            new_tx_data = 1'b1;
            @(negedge clk);
        end
        new_tx_data = 1'b0;
        check("fill_ovf", 32'(overflow), 1);
        check("fill_count", 32'(fifo_count), 16);
        check("fill_busy", 32'(tx_busy), 1);
        check("fill_tx_idle", 32'(tx), 1);

        // unblock and drain; busy drops on the first pop
        tx_block = 1'b0;
        @(negedge clk);
        check("unblk_tx_1", 32'(tx), 1);
        @(negedge clk);
        check("unblk_tx_2", 32'(tx), 1);
        check("unblk_busy_2", 32'(tx_busy), 1);
        @(negedge clk);
        check("unblk_busy_3", 32'(tx_busy), 0);
        check("unblk_count_3", 32'(fifo_count), 15);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            expect_frame(8'(8'h10 + k), -1);
        end
        @(negedge clk);
        check("drain_idle_tx", 32'(tx), 1);
        check("drain_count", 32'(fifo_count), 0);

        // back-to-back
        queue2(8'h00, 8'hFF);
        expect_frame(8'h00, -1);
        @(negedge clk);
        expect_frame(8'hFF, -1);
        @(negedge clk);
        check("b2b_idle_tx", 32'(tx), 1);
        check("b2b_count", 32'(fifo_count), 0);

        // block raised during D3 of the first frame
        queue2(8'h3C, 8'hC3);
        expect_frame(8'h3C, 4 * CPB + 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("blk_hold_tx", 32'(tx), 1);
        end
        check("blk_hold_count", 32'(fifo_count), 1);
        tx_block = 1'b0;
        @(negedge clk);
        check("blk_rel_tx_1", 32'(tx), 1);
        @(negedge clk);
        check("blk_rel_tx_2", 32'(tx), 1);
        @(negedge clk);
        expect_frame(8'hC3, -1);
        @(negedge clk);
        check("blk_idle_tx", 32'(tx), 1);

        // parity / extra data pattern
        queue2(8'h07, 8'h03);
        expect_frame(8'h07, -1);
        @(negedge clk);
        expect_frame(8'h03, -1);
        @(negedge clk);
        check("par_idle_tx", 32'(tx), 1);

        // reset mid-frame
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'(8'h11 * i);
            new_tx_data = 1'b1;
            @(negedge clk);
        end
        new_tx_data = 1'b0;
        check("rstmf_count", 32'(fifo_count), 2);
        repeat (5) @(negedge clk);
        check("rstmf_tx_data0", 32'(tx), 0);
        check("rstmf_ovf_pre", 32'(overflow), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmf_tx_async", 32'(tx), 1);
        check("rstmf_count_async", 32'(fifo_count), 0);
        check("rstmf_ovf_async", 32'(overflow), 0);
        check("rstmf_busy_async", 32'(tx_busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstmf_post_tx", 32'(tx), 1);
            check("rstmf_post_count", 32'(fifo_count), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
